// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared shadow-entry types, forwarding selects and the hazard match helper
// for the LEGv8 hazard unit.
package hazard_unit_pkg;

   // Shadow register fields are stored at this width, so REG_AW may not exceed it.
   localparam int RA_W         = 8;
   localparam int ZERO_REG_DEF = 31;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef struct packed {
      logic            v;
      logic [RA_W-1:0] rd;
      logic            regwrite;
      logic            memread;
   } hz_dst_t;

   typedef struct packed {
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic            use1;
      logic            use2;
   } hz_src_t;

   function automatic logic hz_match(input hz_dst_t e, input logic [RA_W-1:0] r, input logic u,
                                     input logic [RA_W-1:0] zr);
      return u && e.v && e.regwrite && (e.rd != zr) && (e.rd == r);
   endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clock or posedge reset)
      if (reset) cnt <= '0;
      else if (en && !(&cnt)) cnt <= cnt + 1'b1;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, EX operand forwarding and taken-branch flush control for the
// five-stage LEGv8 pipeline, tracking ID/EX, EX/MEM and MEM/WB in private shadow registers.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = ZERO_REG_DEF,
   parameter int BR_FLUSH = 3,
   parameter int FWD_EN   = 1,
   parameter int CNT_W    = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use1,
   input  logic              id_use2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              br_taken,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              idex_bubble,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic              flush_ex_mem,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [RA_W-1:0] ZR = RA_W'(ZERO_REG);

   if (BR_FLUSH < 1 || BR_FLUSH > 3 || REG_AW > RA_W) begin : g_bad_param
      $error("hazard_unit: illegal parameterisation");
   end

   hz_dst_t s_idex, s_exmem, s_memwb;
   hz_src_t s_src;
   logic [RA_W-1:0] rs1, rs2;
   logic hit_ex, hit_mem, hit_wb, load_use, raw_any, stall, idv;

   always_comb begin
      rs1 = RA_W'(id_rs1);
      rs2 = RA_W'(id_rs2);
      hit_ex  = hz_match(s_idex, rs1, id_use1, ZR) || hz_match(s_idex, rs2, id_use2, ZR);
      hit_mem = hz_match(s_exmem, rs1, id_use1, ZR) || hz_match(s_exmem, rs2, id_use2, ZR);
      hit_wb  = hz_match(s_memwb, rs1, id_use1, ZR) || hz_match(s_memwb, rs2, id_use2, ZR);
      load_use = id_valid && s_idex.memread && hit_ex;
      raw_any  = id_valid && (hit_ex || hit_mem || hit_wb);
      stall = (FWD_EN != 0 ? load_use : raw_any) && !br_taken;
      idv = id_valid && !stall && !br_taken;
      pc_write     = !stall;
      if_id_write  = !stall;
      idex_bubble  = stall;
      flush_if_id  = br_taken;
      flush_id_ex  = br_taken && (BR_FLUSH >= 2);
      flush_ex_mem = br_taken && (BR_FLUSH == 3);
      // EX/MEM is checked first: it holds the younger of two writers to the same register.
      fwd_a = FWD_EN == 0                                 ? FWD_REG   :
              hz_match(s_exmem, s_src.rs1, s_src.use1, ZR) ? FWD_EXMEM :
              hz_match(s_memwb, s_src.rs1, s_src.use1, ZR) ? FWD_MEMWB : FWD_REG;
      fwd_b = FWD_EN == 0                                 ? FWD_REG   :
              hz_match(s_exmem, s_src.rs2, s_src.use2, ZR) ? FWD_EXMEM :
              hz_match(s_memwb, s_src.rs2, s_src.use2, ZR) ? FWD_MEMWB : FWD_REG;
   end

   // Source-use bits follow the entry's valid so a bubble never requests forwarding.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         s_idex  <= '0;
         s_exmem <= '0;
         s_memwb <= '0;
         s_src   <= '0;
      end else begin
         s_memwb   <= s_exmem;
         s_memwb.v <= s_exmem.v && !flush_ex_mem;
         s_exmem   <= s_idex;
         s_exmem.v <= s_idex.v && !flush_id_ex;
         s_idex    <= '{idv, RA_W'(id_rd), id_regwrite, id_memread};
         s_src     <= '{rs1, rs2, id_use1 && idv, id_use2 && idv};
      end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clock(clock), .reset(reset), .en(stall), .cnt(stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clock(clock), .reset(reset), .en(br_taken), .cnt(flush_cnt)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors against two hazard_unit builds (default, and FWD_EN=0 /
// BR_FLUSH=1 / 2-bit counters) with a queue-based scoreboard checked by a separate monitor.
module tb_hazard_unit;

   logic clock = 0, reset = 1, strobe = 0;
   logic id_valid, id_use1, id_use2, id_regwrite, id_memread, br_taken;
   logic [4:0] id_rs1, id_rs2, id_rd;

   logic pcw0, ifw0, bub0, fif0, fie0, fem0, pcw1, ifw1, bub1, fif1, fie1, fem1;
   logic [1:0] fa0, fb0, fa1, fb1;
   logic [31:0] sc0, fc0;
   logic [1:0] sc1, fc1;

   always #5 clock = ~clock;

   hazard_unit dut0 (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .br_taken(br_taken), .pc_write(pcw0), .if_id_write(ifw0),
      .idex_bubble(bub0), .flush_if_id(fif0), .flush_id_ex(fie0), .flush_ex_mem(fem0),
      .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(sc0), .flush_cnt(fc0)
   );

   hazard_unit #(.FWD_EN(0), .BR_FLUSH(1), .CNT_W(2)) dut1 (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .br_taken(br_taken), .pc_write(pcw1), .if_id_write(ifw1),
      .idex_bubble(bub1), .flush_if_id(fif1), .flush_id_ex(fie1), .flush_ex_mem(fem1),
      .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1)
   );

   // o = {pc_write, if_id_write, idex_bubble, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b}
   typedef struct {
      int          dut;
      string       name;
      logic [9:0]  o;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t q[$];
   exp_t e;
   logic [9:0] ao;
   logic [31:0] asc, afc;
   int vectors = 0, miscompares = 0;

   always begin
      @(negedge clock or posedge strobe);
      while (q.size() > 0) begin
         e = q.pop_front();
         ao  = e.dut == 0 ? {pcw0, ifw0, bub0, fif0, fie0, fem0, fa0, fb0}
                          : {pcw1, ifw1, bub1, fif1, fie1, fem1, fa1, fb1};
         asc = e.dut == 0 ? sc0 : {30'b0, sc1};
         afc = e.dut == 0 ? fc0 : {30'b0, fc1};
         vectors++;
         if (ao !== e.o || asc !== e.sc || afc !== e.fc) begin
            miscompares++;
            $display("FAIL %s: got o=%b stall_cnt=%0d flush_cnt=%0d, expected o=%b stall_cnt=%0d flush_cnt=%0d",
                     e.name, ao, asc, afc, e.o, e.sc, e.fc);
         end
      end
   end

   task automatic ex(input int d, input string n, input logic st, input logic [2:0] fl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] sc,
                     input logic [31:0] fc);
      q.push_back('{d, n, {!st, !st, st, fl, fa, fb}, sc, fc});
   endtask

   task automatic drv(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                      input logic u2, input logic [4:0] rd, input logic rw, input logic mr,
                      input logic br);
      id_valid = v; id_rs1 = r1; id_use1 = u1; id_rs2 = r2; id_use2 = u2;
      id_rd = rd; id_regwrite = rw; id_memread = mr; br_taken = br;
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rst_pulse();
      cyc();
      idle();
      reset = 1;
      #2 reset = 0;
   endtask

   task automatic pulse_strobe();
      #1 strobe = 1;
      #1 strobe = 0;
   endtask

   initial begin
      idle();
      #1;
      ex(0, "reset_state0", 0, 3'b000, 2'b00, 2'b00, 0, 0);
      ex(1, "reset_state1", 0, 3'b000, 2'b00, 2'b00, 0, 0);
      pulse_strobe();
      reset = 0;

      // LDUR X1,[X2] then ADD X2,X1,X3
      cyc(); drv(1, 2, 1, 0, 0, 1, 1, 1, 0); ex(0, "ldur_issue", 0, 3'b000, 2'b00, 2'b00, 0, 0);
      cyc(); drv(1, 1, 1, 3, 1, 2, 1, 0, 0); ex(0, "ld_use_stall", 1, 3'b000, 2'b00, 2'b00, 0, 0);
      cyc(); ex(0, "ld_use_one_cycle", 0, 3'b000, 2'b00, 2'b00, 1, 0);
      cyc(); idle(); ex(0, "ld_use_fwd_memwb", 0, 3'b000, 2'b01, 2'b00, 1, 0);

      // ADD X1,X2,X3 then SUB X4,X1,X1
      rst_pulse();
      cyc(); drv(1, 2, 1, 3, 1, 1, 1, 0, 0);
      cyc(); drv(1, 1, 1, 1, 1, 4, 1, 0, 0); ex(0, "alu_no_stall", 0, 3'b000, 2'b00, 2'b00, 0, 0);
      cyc(); idle(); ex(0, "alu_fwd_exmem_ab", 0, 3'b000, 2'b10, 2'b10, 0, 0);

      // ADD X1, ADD X1, ORR X5,X1,X2
      rst_pulse();
      cyc(); drv(1, 2, 1, 3, 1, 1, 1, 0, 0);
      cyc(); drv(1, 2, 1, 3, 1, 1, 1, 0, 0);
      cyc(); drv(1, 1, 1, 2, 1, 5, 1, 0, 0);
      cyc(); idle(); ex(0, "younger_writer_wins", 0, 3'b000, 2'b10, 2'b00, 0, 0);

      // LDUR XZR then a reader of XZR
      rst_pulse();
      cyc(); drv(1, 2, 1, 0, 0, 31, 1, 1, 0);
      cyc(); drv(1, 31, 1, 31, 1, 5, 1, 0, 0);
      ex(0, "xzr_no_stall", 0, 3'b000, 2'b00, 2'b00, 0, 0);
      ex(1, "xzr_no_stall_nofwd", 0, 3'b000, 2'b00, 2'b00, 0, 0);
      cyc(); idle(); ex(0, "xzr_no_fwd", 0, 3'b000, 2'b00, 2'b00, 0, 0);

      // taken branch in the same cycle as a load-use
      rst_pulse();
      cyc(); drv(1, 2, 1, 0, 0, 1, 1, 1, 0);
      cyc(); drv(1, 1, 1, 3, 1, 2, 1, 0, 1);
      ex(0, "branch_beats_stall", 0, 3'b111, 2'b00, 2'b00, 0, 0);
      ex(1, "br_flush_depth1", 0, 3'b100, 2'b00, 2'b00, 0, 0);
      cyc(); idle();
      ex(0, "flush_cnt_one", 0, 3'b000, 2'b00, 2'b00, 0, 1);
      ex(1, "flush_cnt_one_d1", 0, 3'b000, 2'b00, 2'b00, 0, 1);

      // FWD_EN=0: ADD X1 then SUB X4,X1,X1 stalls 3 cycles; 2-bit stall counter saturates
      rst_pulse();
      cyc(); drv(1, 2, 1, 3, 1, 1, 1, 0, 0);
      cyc(); drv(1, 1, 1, 1, 1, 4, 1, 0, 0); ex(1, "raw_stall_1", 1, 3'b000, 2'b00, 2'b00, 0, 0);
      cyc(); ex(1, "raw_stall_2", 1, 3'b000, 2'b00, 2'b00, 1, 0);
      cyc(); ex(1, "raw_stall_3", 1, 3'b000, 2'b00, 2'b00, 2, 0);
      cyc(); ex(1, "raw_release", 0, 3'b000, 2'b00, 2'b00, 3, 0);
      cyc(); drv(1, 4, 1, 4, 1, 7, 1, 0, 0); ex(1, "sat_stall_a", 1, 3'b000, 2'b00, 2'b00, 3, 0);
      cyc(); ex(1, "sat_hold_b", 1, 3'b000, 2'b00, 2'b00, 3, 0);
      cyc(); ex(1, "sat_hold_c", 1, 3'b000, 2'b00, 2'b00, 3, 0);

      // reset asserted in the middle of a load-use stall
      rst_pulse();
      cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(); drv(1, 2, 1, 0, 0, 1, 1, 1, 0);
      cyc(); drv(1, 1, 1, 3, 1, 2, 1, 0, 0); ex(0, "pre_reset_stall", 1, 3'b000, 2'b00, 2'b00, 0, 1);
      @(negedge clock);
      #1 reset = 1;
      #1 ex(0, "async_reset_mid_stall", 0, 3'b000, 2'b00, 2'b00, 0, 0);
      pulse_strobe();
      cyc(); reset = 0; ex(0, "post_reset_clean", 0, 3'b000, 2'b00, 2'b00, 0, 0);

      cyc(); idle();
      cyc();
      cyc();
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d expected entries left unchecked, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised hazard-detection, forwarding and flush controller for the five-stage LEGv8 pipeline.
- Keeps its own shadow copy of the destination and source fields for the ID/EX, EX/MEM and MEM/WB pipeline registers.
- From that state it produces load-use stalls, EX operand forwarding selects and branch-squash flushes.
- Branch resolution depth is configurable, and the block keeps stall/flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- ZERO_REG, 31, XZR index: never a hazard source, never forwarded.
- BR_FLUSH, 3, number of younger instructions squashed on a taken branch (legal 1..3).
- FWD_EN, 1, 1 enables forwarding; 0 forces fwd selects to 00 and stalls on every RAW hazard.
- CNT_W, 32, performance counter width.

Ports:
- clock, input, 1, pipeline clock.
- reset, input, 1, asynchronous active-high reset.
- id_valid, input, 1, the IF/ID register holds a real instruction.
- id_rs1, input, REG_AW, first source register of the ID instruction.
- id_rs2, input, REG_AW, second source register (post reg2loc mux).
- id_use1, input, 1, ID instruction reads rs1.
- id_use2, input, 1, ID instruction reads rs2.
- id_rd, input, REG_AW, destination register of the ID instruction.
- id_regwrite, input, 1, ID instruction writes rd.
- id_memread, input, 1, ID instruction is a load.
- br_taken, input, 1, branch taken; resolved in the stage selected by BR_FLUSH.
- pc_write, output, 1, PC may update.
- if_id_write, output, 1, IF/ID register may load.
- idex_bubble, output, 1, zero the control fields entering ID/EX.
- flush_if_id, output, 1, squash the IF/ID register.
- flush_id_ex, output, 1, squash the ID/EX register.
- flush_ex_mem, output, 1, squash the EX/MEM register.
- fwd_a, output, 2, EX operand A select: 00 register file, 10 EX/MEM, 01 MEM/WB.
- fwd_b, output, 2, EX operand B select, same encoding.
- stall_cnt, output, CNT_W, number of cycles stalled.
- flush_cnt, output, CNT_W, number of taken-branch flush events.

Behaviour:
- Shadow entries: s_idex holds {v, rd, regwrite, memread, rs1, rs2, use1, use2}; s_exmem and s_memwb hold {v, rd, regwrite, memread}.
- A "writer" is an entry with v=1, regwrite=1 and rd!=ZERO_REG.
- match(e, r, u) means u=1, e is a writer, and e.rd==r. A match on either ID source counts as a hazard against entry e.
- load_use: id_valid is high and s_idex is a writer with memread=1 that matches an ID source.
- raw_any: id_valid is high and s_idex, s_exmem or s_memwb matches an ID source. Only used when FWD_EN=0.
- stall = (FWD_EN ? load_use : raw_any) and not br_taken. Flush always wins over stall.
- Outputs are combinational:
  - pc_write = if_id_write = not stall.
  - idex_bubble = stall.
  - flush_if_id = br_taken.
  - flush_id_ex = br_taken when BR_FLUSH>=2, else 0.
  - flush_ex_mem = br_taken when BR_FLUSH==3, else 0.
- A taken branch keeps pc_write=1, so the target address loads.
- Forwarding for s_idex sources, when FWD_EN=1:
  - fwd_a = 10 if s_exmem matches (rs1, use1); else 01 if s_memwb matches; else 00.
  - fwd_b is the same for (rs2, use2).
  - EX/MEM has priority over MEM/WB because it holds the younger result.
- Register file is write-first, so ID reads against the MEM/WB writer need no forwarding in ID.
- Shadow update on each rising clock edge:
  - s_memwb <= s_exmem, with v cleared if flush_ex_mem.
  - s_exmem <= s_idex, with v cleared if flush_id_ex.
  - s_idex <= ID fields with v = id_valid and not stall and not flush_if_id.
  - A bubble is inserted on stall, and the IF/ID contents are held, not re-captured.
- Counters:
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with br_taken=1.
  - Both saturate at all-ones; no wrap.
- Reset (async, any time, including mid-stall or mid-flush):
  - all shadow v=0 and counters=0.
  - Resulting outputs: pc_write=1, if_id_write=1, idex_bubble=0, all flushes 0, fwd=00.
  - Deassertion takes effect at the next clock edge; no partial state is retained.
- Latency: zero-cycle combinational response to the ID inputs and shadow state; shadow state has one-cycle update latency.
- A load-use stall lasts exactly 1 cycle with FWD_EN=1, and up to 3 cycles with FWD_EN=0.

Decomposition:
- Shared package holds:
  - fwd select constants FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01.
  - the shadow-entry struct typedef.
  - the default ZERO_REG constant.
- One sub-module is natural: sat_counter (CNT_W, en, clock, reset), instantiated twice.

Test Plan:
- LDUR X1 followed by ADD X2,X1,X3 (FWD_EN=1) -> exactly one cycle of pc_write=0, if_id_write=0, idex_bubble=1; next cycle fwd_a=01; stall_cnt=1.
- ADD X1 then SUB X4,X1,X1 -> no stall; fwd_a=10 and fwd_b=10 in SUB's EX cycle.
- ADD X1, ADD X1, then ORR X5,X1,X2 -> fwd_a=10 (younger writer wins over the MEM/WB copy).
- Writer to X31 followed by a reader of X31 -> no stall, fwd=00.
- br_taken in the same cycle as a load-use condition (BR_FLUSH=3) -> stall=0, pc_write=1, all three flushes=1; flush_cnt=1, stall_cnt unchanged.
- BR_FLUSH=1 -> only flush_if_id asserted. FWD_EN=0 with an ADD X1 dependency -> 3 stall cycles.
- Reset asserted mid-stall -> outputs take reset values immediately without a clock edge; counters = 0.
- Force stall_cnt to all-ones minus 1 and stall twice -> counter holds at all-ones.
